// File: rtl/spi_master_ctrl.sv
// Command-driven SPI master: frames {op, data} onto SS_n/MOSI, MSB first, one bit per clk,
// and for read-data commands (op 2'b11) captures ADDR_SIZE bits from MISO after RD_LAT idle cycles.
module spi_master_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    // Handshake: a command is taken on any posedge where cmd_valid && cmd_ready;
    // cmd_ready is high only while the FSM sits in S_IDLE, so no back-pressure exists elsewhere.

    localparam int WORD_W = ADDR_SIZE + 2;
    localparam int CNT_W  = $clog2(WORD_W + RD_LAT + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SHIFT   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_END     = 3'd5
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_W-1:0]     sreg;
    logic [ADDR_SIZE-1:0]  cap;
    logic                  is_read;
    logic                  accept;

    assign dbg_state = state;

    always_comb begin
        state_d = state;
        accept  = cmd_valid && cmd_ready;
        case (state)
            S_IDLE:    if (accept) state_d = S_START;
            S_START:   state_d = S_SHIFT;
            S_SHIFT:   if (cnt == SHIFT_LAST) state_d = is_read ? S_WAIT : S_END;
            S_WAIT:    if (cnt == WAIT_LAST) state_d = S_CAPTURE;
            S_CAPTURE: if (cnt == CAP_LAST) state_d = S_END;
            S_END:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            cap       <= '0;
            is_read   <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= (state_d == state) ? cnt + CNT_W'(1) : '0;
            busy      <= (state_d != S_IDLE);
            cmd_ready <= (state_d == S_IDLE);
            SS_n      <= (state_d == S_IDLE) || (state_d == S_END);
            MOSI      <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sreg    <= {cmd_op, cmd_data};
                        is_read <= (cmd_op == 2'b11);
                        MOSI    <= cmd_op[1];
                    end
                end
                S_START, S_SHIFT: begin
                    if (state_d == S_SHIFT) begin
                        MOSI <= sreg[WORD_W-1];
                        sreg <= sreg << 1;
                    end
                end
                S_CAPTURE: begin
                    cap <= {cap[ADDR_SIZE-2:0], MISO};
                    if (state_d == S_END) begin
                        rd_data  <= {cap[ADDR_SIZE-2:0], MISO};
                        rd_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (8-bit/RD_LAT=2 and 6-bit/RD_LAT=4) checked cycle by
// cycle against a frame-timeline model derived from the command, the field width and the read latency.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid0, cmd_valid1;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       MISO;

    logic       cmd_ready0, ss_n0, mosi0, rd_valid0, busy0;
    logic [7:0] rd_data0;
    logic [2:0] dbg_state0;
    logic       cmd_ready1, ss_n1, mosi1, rd_valid1, busy1;
    logic [5:0] rd_data1;
    logic [2:0] dbg_state1;

    int         vectors = 0;
    int         fails = 0;
    logic [7:0] model_rd [2];

    // Observation word: {SS_n, MOSI, rd_valid, busy, cmd_ready, rd_data}
    logic [12:0] obs [2];
    assign obs[0] = {ss_n0, mosi0, rd_valid0, busy0, cmd_ready0, rd_data0};
    assign obs[1] = {ss_n1, mosi1, rd_valid1, busy1, cmd_ready1, 2'b00, rd_data1};

    always #5 clk = ~clk;

    spi_master_ctrl #(.ADDR_SIZE(8), .RD_LAT(2)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(ss_n0), .MOSI(mosi0), .MISO(MISO),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0), .dbg_state(dbg_state0)
    );

    spi_master_ctrl #(.ADDR_SIZE(6), .RD_LAT(4)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_data(cmd_data[5:0]), .SS_n(ss_n1), .MOSI(mosi1), .MISO(MISO),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .dbg_state(dbg_state1)
    );

    // One full frame on instance sel, starting at a negedge. Cycle k counts from the accept cycle t.
    // Returns at the negedge of the IDLE cycle after END, so a following call can accept immediately.
    task automatic run_frame(input string name, input int sel, input logic [1:0] op,
                             input logic [7:0] data, input logic [7:0] rdw_in, input int abort_at);
        int          w, lat, endk, cap0, waitc;
        logic [7:0]  rdw;
        logic [12:0] exp;
        logic        e_mosi;
        w    = (sel == 1) ? 6 : 8;
        lat  = (sel == 1) ? 4 : 2;
        rdw  = (sel == 1) ? {2'b00, rdw_in[5:0]} : rdw_in;
        endk = (op == 2'b11) ? 2 * w + lat + 4 : w + 4;
        cap0 = w + 4 + lat;
        waitc = 0;
        while (obs[sel][8] !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (obs[sel][8] !== 1'b1) begin
            vectors++;
            fails++;
            $display("FAIL %s dut%0d cmd_ready timeout: got %b want 1", name, sel, obs[sel][8]);
            return;
        end
        cmd_op   = op;
        cmd_data = data;
        if (sel == 1) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
        for (int k = 1; k <= endk + 1; k++) begin
            @(negedge clk);
            if (k == 1)          e_mosi = op[1];
            else if (k == 2)     e_mosi = op[1];
            else if (k == 3)     e_mosi = op[0];
            else if (k <= w + 3) e_mosi = data[w - 1 - (k - 4)];
            else                 e_mosi = 1'b0;
            if (k == endk && op == 2'b11) model_rd[sel] = rdw;
            if (k <= endk)
                exp = {(k == endk), e_mosi, (op == 2'b11 && k == endk), 1'b1, 1'b0, model_rd[sel]};
            else
                exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, model_rd[sel]};
            vectors++;
            if (obs[sel] !== exp) begin
                fails++;
                $display("FAIL %s dut%0d cycle t+%0d {ss,mosi,rv,busy,rdy,rd}: got %b want %b",
                         name, sel, k, obs[sel], exp);
            end
            // Garbage on the command inputs mid-frame must be ignored.
            if (k <= endk) begin
                if (sel == 1) cmd_valid1 = 1'($urandom_range(0, 1));
                else          cmd_valid0 = 1'($urandom_range(0, 1));
                cmd_op   = 2'($urandom_range(0, 3));
                cmd_data = 8'($urandom_range(0, 255));
            end else begin
                cmd_valid0 = 1'b0;
                cmd_valid1 = 1'b0;
            end
            if (op == 2'b11 && k >= cap0 && k < cap0 + w) MISO = rdw[w - 1 - (k - cap0)];
            else                                           MISO = 1'($urandom_range(0, 1));
            if (k == abort_at) begin
                rst        = 1'b1;
                cmd_valid0 = 1'b0;
                cmd_valid1 = 1'b0;
                @(negedge clk);
                model_rd[0] = 8'h00;
                model_rd[1] = 8'h00;
                for (int s = 0; s < 2; s++) begin
                    vectors++;
                    if (obs[s] !== 13'h1000) begin
                        fails++;
                        $display("FAIL %s dut%0d after abort: got %b want %b", name, s, obs[s], 13'h1000);
                    end
                end
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid0 = 1'b1;
        cmd_valid1 = 1'b1;
        cmd_op = 2'b11;
        cmd_data = 8'hFF;
        MISO = 1'b0;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                vectors++;
                if (obs[s] !== 13'h1000) begin
                    fails++;
                    $display("FAIL reset dut%0d cycle %0d: got %b want %b", s, c, obs[s], 13'h1000);
                end
            end
        end
        rst = 1'b0;
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (obs[s] !== 13'h1100) begin
                fails++;
                $display("FAIL reset_release dut%0d: got %b want %b", s, obs[s], 13'h1100);
            end
        end
    endtask

    task automatic test_write_addr();
        run_frame("write_addr", 0, 2'b00, 8'hA5, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        run_frame("write_data_b2b", 0, 2'b01, 8'h3C, 8'h00, 0);
    endtask

    task automatic test_read();
        run_frame("read_data", 0, 2'b11, 8'h17, 8'hC3, 0);
        run_frame("write_after_read", 0, 2'b10, 8'h81, 8'h00, 0);
    endtask

    task automatic test_reset_mid_capture();
        run_frame("abort_read", 0, 2'b11, 8'h00, 8'hC3, 16);
        run_frame("read_after_abort", 0, 2'b11, 8'h42, 8'h5A, 0);
    endtask

    task automatic test_alt_params();
        run_frame("alt_read", 1, 2'b11, 8'h2D, 8'h2B, 0);
        run_frame("alt_write", 1, 2'b01, 8'h15, 8'h00, 0);
        run_frame("alt_read2", 1, 2'b11, 8'h00, 8'h14, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_frame("random", (i % 4 == 3) ? 1 : 0, 2'($urandom_range(0, 3)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_read();
        test_reset_mid_capture();
        test_alt_params();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
